mips_alu_exec_unit: RTL and testbench

- Execute-stage arithmetic block for the multicycle MIPS CPU. It merges three functions:
  - ALU-control decode.
  - The 32-bit integer ALU with branch-condition flag.
  - The branch-target adder.
- Combinational results feed the register-file write mux, memory address mux and PC mux.
- Registered copies (ALUOut-style) hold values across multicycle states.

---
 rtl/mips_alu_exec_unit_if.sv | 29 ++
 rtl/mips_alu_exec_unit.sv | 120 ++++++++++++
 tb/tb_mips_alu_exec_unit.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_alu_exec_unit_if.sv
// Operand/result bundle between the multicycle control/datapath and the execute unit.
// The master drives operands and instruction fields; the slave returns ALU results.
interface mips_alu_exec_unit_if;
  logic        en;
  logic [3:0]  alu_op;
  logic [5:0]  funct;
  logic [4:0]  rt_field;
  logic [4:0]  shamt;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] pc;
  logic [15:0] imm16;
  logic [3:0]  alu_ctrl;
  logic [31:0] result;
  logic        zero;
  logic [31:0] branch_target;
  logic [31:0] result_q;
  logic        zero_q;

  modport master (
    output en, alu_op, funct, rt_field, shamt, a, b, pc, imm16,
    input  alu_ctrl, result, zero, branch_target, result_q, zero_q
  );

  modport slave (
    input  en, alu_op, funct, rt_field, shamt, a, b, pc, imm16,
    output alu_ctrl, result, zero, branch_target, result_q, zero_q
  );
endinterface

// File: rtl/mips_alu_exec_unit.sv
// Execute stage for the multicycle MIPS: ALU-control decode, 32-bit ALU with
// branch-condition flag, branch-target adder and ALUOut-style result registers.
module mips_alu_exec_unit (
  input  logic clk,
  input  logic reset,
  mips_alu_exec_unit_if.slave bus
);

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,  OP_SUB   = 4'd1,  OP_AND   = 4'd2,  OP_OR    = 4'd3,
    OP_XOR   = 4'd4,  OP_NOR   = 4'd5,  OP_SLT   = 4'd6,  OP_SLTU  = 4'd7,
    OP_SLL   = 4'd8,  OP_SRL   = 4'd9,  OP_SRA   = 4'd10, OP_LUI   = 4'd11,
    OP_PASSA = 4'd12, OP_SLLV  = 4'd13, OP_SRLV  = 4'd14, OP_SRAV  = 4'd15
  } alu_ctrl_e;

  alu_ctrl_e   funct_ctrl;
  alu_ctrl_e   ctrl;
  logic [31:0] res;
  logic        zero;
  logic [31:0] result_d, result_q;
  logic        zero_d, zero_q;
  logic [3:0]  unused_rt;

  assign unused_rt = bus.rt_field[4:1];

  always_comb begin
    funct_ctrl = OP_ADD;
    case (bus.funct)
      6'h20, 6'h21: funct_ctrl = OP_ADD;
      6'h22, 6'h23: funct_ctrl = OP_SUB;
      6'h24:        funct_ctrl = OP_AND;
      6'h25:        funct_ctrl = OP_OR;
      6'h26:        funct_ctrl = OP_XOR;
      6'h27:        funct_ctrl = OP_NOR;
      6'h2A:        funct_ctrl = OP_SLT;
      6'h2B:        funct_ctrl = OP_SLTU;
      6'h00:        funct_ctrl = OP_SLL;
      6'h02:        funct_ctrl = OP_SRL;
      6'h03:        funct_ctrl = OP_SRA;
      6'h04:        funct_ctrl = OP_SLLV;
      6'h06:        funct_ctrl = OP_SRLV;
      6'h07:        funct_ctrl = OP_SRAV;
      6'h08, 6'h09: funct_ctrl = OP_PASSA;
      default:      funct_ctrl = OP_ADD;
    endcase
  end

  always_comb begin
    ctrl = OP_ADD;
    case (bus.alu_op)
      4'd1:                      ctrl = OP_SUB;
      4'd2:                      ctrl = funct_ctrl;
      4'd3:                      ctrl = OP_AND;
      4'd4:                      ctrl = OP_OR;
      4'd5:                      ctrl = OP_XOR;
      4'd6:                      ctrl = OP_SLT;
      4'd7:                      ctrl = OP_SLTU;
      4'd8:                      ctrl = OP_LUI;
      4'd9, 4'd10, 4'd11, 4'd12: ctrl = OP_SUB;
      default:                   ctrl = OP_ADD;
    endcase
  end

  always_comb begin
    res = '0;
    case (ctrl)
      OP_ADD:   res = bus.a + bus.b;
      OP_SUB:   res = bus.a - bus.b;
      OP_AND:   res = bus.a & bus.b;
      OP_OR:    res = bus.a | bus.b;
      OP_XOR:   res = bus.a ^ bus.b;
      OP_NOR:   res = ~(bus.a | bus.b);
      OP_SLT:   res = {31'd0, $signed(bus.a) < $signed(bus.b)};
      OP_SLTU:  res = {31'd0, bus.a < bus.b};
      OP_SLL:   res = bus.b << bus.shamt;
      OP_SRL:   res = bus.b >> bus.shamt;
      OP_SRA:   res = 32'($signed(bus.b) >>> bus.shamt);
      OP_LUI:   res = {bus.b[15:0], 16'h0000};
      OP_PASSA: res = bus.a;
      OP_SLLV:  res = bus.b << bus.a[4:0];
      OP_SRLV:  res = bus.b >> bus.a[4:0];
      OP_SRAV:  res = 32'($signed(bus.b) >>> bus.a[4:0]);
      default:  res = '0;
    endcase
  end

  // Branch classes override the result==0 flag with their own condition on rs.
  always_comb begin
    zero = (res == '0);
    case (bus.alu_op)
      4'd1:    zero = (bus.a == bus.b);
      4'd12:   zero = (bus.a != bus.b);
      4'd9:    zero = bus.rt_field[0] ? ~bus.a[31] : bus.a[31];
      4'd10:   zero = ~bus.a[31] & (|bus.a);
      4'd11:   zero = bus.a[31] | ~(|bus.a);
      default: zero = (res == '0);
    endcase
  end

  assign result_d = bus.en ? res  : result_q;
  assign zero_d   = bus.en ? zero : zero_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.alu_ctrl      = ctrl;
  assign bus.result        = res;
  assign bus.zero          = zero;
  assign bus.branch_target = bus.pc + {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
  assign bus.result_q      = result_q;
  assign bus.zero_q        = zero_q;

endmodule

// File: tb/tb_mips_alu_exec_unit.sv
// Self-checking bench for mips_alu_exec_unit: literal directed cases plus
// randomized operands compared every cycle against a behavioural model.
module tb_mips_alu_exec_unit;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  mips_alu_exec_unit_if bus ();

  mips_alu_exec_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_ctrl(input logic [3:0] op, input logic [5:0] f);
    case (op)
      4'd0: return 0;
      4'd1: return 1;
      4'd2: begin
        case (f)
          6'h20, 6'h21: return 0;
          6'h22, 6'h23: return 1;
          6'h24: return 2;
          6'h25: return 3;
          6'h26: return 4;
          6'h27: return 5;
          6'h2A: return 6;
          6'h2B: return 7;
          6'h00: return 8;
          6'h02: return 9;
          6'h03: return 10;
          6'h04: return 13;
          6'h06: return 14;
          6'h07: return 15;
          6'h08, 6'h09: return 12;
          default: return 0;
        endcase
      end
      4'd3: return 2;
      4'd4: return 3;
      4'd5: return 4;
      4'd6: return 6;
      4'd7: return 7;
      4'd8: return 11;
      4'd9, 4'd10, 4'd11, 4'd12: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] m_sra(input logic [31:0] v, input int s);
    logic [31:0] r;
    r = v;
    for (int i = 0; i < s; i++) r = {r[31], r[31:1]};
    return r;
  endfunction

  function automatic logic [31:0] m_res(input int c, input logic [31:0] a,
                                         input logic [31:0] b, input logic [4:0] sh);
    int sv;
    sv = int'(a[4:0]);
    case (c)
      0:  return a + b;
      1:  return a - b;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return ~(a | b);
      6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      7:  return (a < b) ? 32'd1 : 32'd0;
      8:  return b << sh;
      9:  return b >> sh;
      10: return m_sra(b, int'(sh));
      11: return b * 32'h0001_0000;
      12: return a;
      13: return b << sv;
      14: return b >> sv;
      default: return m_sra(b, sv);
    endcase
  endfunction

  function automatic logic m_zero(input logic [3:0] op, input logic [4:0] rt,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] r);
    case (op)
      4'd1:  return a == b;
      4'd12: return a != b;
      4'd9:  return rt[0] ? ($signed(a) >= 0) : ($signed(a) < 0);
      4'd10: return $signed(a) > 0;
      4'd11: return $signed(a) <= 0;
      default: return r == 32'd0;
    endcase
  endfunction

  logic [31:0] exp_res, exp_bt, exp_rq;
  logic        exp_z, exp_zq, exp_known;
  int          exp_ctrl;

  always_comb begin
    exp_ctrl = m_ctrl(bus.alu_op, bus.funct);
    exp_res  = m_res(exp_ctrl, bus.a, bus.b, bus.shamt);
    exp_z    = m_zero(bus.alu_op, bus.rt_field, bus.a, bus.b, exp_res);
    exp_bt   = bus.pc + 32'($signed({{16{bus.imm16[15]}}, bus.imm16}) * 4);
  end

  initial exp_known = 1'b0;

  always @(posedge clk) begin
    if (!reset) begin
      exp_rq    <= 32'd0;
      exp_zq    <= 1'b0;
      exp_known <= 1'b1;
    end else if (bus.en) begin
      exp_rq <= exp_res;
      exp_zq <= exp_z;
    end
  end

  always @(negedge clk) begin
    chk("alu_ctrl", {28'd0, bus.alu_ctrl}, 32'(exp_ctrl));
    chk("result", bus.result, exp_res);
    chk("zero", {31'd0, bus.zero}, {31'd0, exp_z});
    chk("branch_target", bus.branch_target, exp_bt);
    if (exp_known) begin
      chk("result_q", bus.result_q, exp_rq);
      chk("zero_q", {31'd0, bus.zero_q}, {31'd0, exp_zq});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [5:0] fl [17] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                          6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08};

  initial begin
    checks   = 0;
    failures = 0;
    reset = 1'b0;
    bus.en = 1'b1;  bus.alu_op = 4'd0; bus.funct = 6'h20; bus.rt_field = '0;
    bus.shamt = '0; bus.a = 32'd5;     bus.b = 32'd7;     bus.pc = '0;
    bus.imm16 = '0;

    step();
    chk("rst_result_q", bus.result_q, 32'd0);
    chk("rst_zero_q", {31'd0, bus.zero_q}, 32'd0);
    reset = 1'b1;
    step();
    chk("first_result_q", bus.result_q, 32'd12);
    chk("first_zero_q", {31'd0, bus.zero_q}, 32'd0);

    bus.alu_op = 4'd2; bus.funct = 6'h23; bus.a = 32'd0; bus.b = 32'd1;
    @(negedge clk);
    chk("subu_result", bus.result, 32'hFFFF_FFFF);
    chk("subu_ctrl", {28'd0, bus.alu_ctrl}, 32'd1);
    step();
    bus.funct = 6'h2A; bus.a = 32'hFFFF_FFFF; bus.b = 32'd1;
    @(negedge clk);
    chk("slt_result", bus.result, 32'd1);
    step();
    bus.funct = 6'h2B;
    @(negedge clk);
    chk("sltu_result", bus.result, 32'd0);
    step();
    bus.funct = 6'h03; bus.shamt = 5'd4; bus.b = 32'h8000_0000;
    @(negedge clk);
    chk("sra_result", bus.result, 32'hF800_0000);
    step();
    bus.funct = 6'h06; bus.a = 32'h24; bus.b = 32'hF0;
    @(negedge clk);
    chk("srlv_result", bus.result, 32'h0000_000F);
    step();
    bus.alu_op = 4'd8; bus.b = 32'h1234;
    @(negedge clk);
    chk("lui_result", bus.result, 32'h1234_0000);
    step();
    bus.alu_op = 4'd1; bus.a = 32'd9; bus.b = 32'd9;
    @(negedge clk);
    chk("beq_zero", {31'd0, bus.zero}, 32'd1);
    step();
    bus.alu_op = 4'd12;
    @(negedge clk);
    chk("bne_zero", {31'd0, bus.zero}, 32'd0);
    step();
    bus.alu_op = 4'd9; bus.rt_field = 5'd1; bus.a = 32'd0;
    @(negedge clk);
    chk("bgez_zero", {31'd0, bus.zero}, 32'd1);
    step();
    bus.alu_op = 4'd10;
    @(negedge clk);
    chk("bgtz_zero", {31'd0, bus.zero}, 32'd0);
    step();
    bus.alu_op = 4'd11; bus.a = 32'h8000_0000;
    @(negedge clk);
    chk("blez_zero", {31'd0, bus.zero}, 32'd1);
    step();
    bus.pc = 32'hBFC0_0004; bus.imm16 = 16'hFFFF;
    @(negedge clk);
    chk("bt_neg", bus.branch_target, 32'hBFC0_0000);
    step();
    bus.imm16 = 16'h0003;
    @(negedge clk);
    chk("bt_pos", bus.branch_target, 32'hBFC0_0010);
    step();
    bus.alu_op = 4'd2; bus.funct = 6'h08; bus.a = 32'hDEAD_BEEF; bus.en = 1'b1;
    @(negedge clk);
    chk("jr_result", bus.result, 32'hDEAD_BEEF);
    step();
    chk("jr_result_q", bus.result_q, 32'hDEAD_BEEF);
    bus.en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.alu_op = 4'($urandom_range(0, 15));
      bus.a = $urandom; bus.b = 32'd0; bus.funct = 6'h20;
      step();
      chk("hold_result_q", bus.result_q, 32'hDEAD_BEEF);
      chk("hold_zero_q", {31'd0, bus.zero_q}, 32'd0);
    end

    for (int i = 0; i < 1500; i++) begin
      bus.alu_op   = 4'($urandom_range(0, 15));
      bus.funct    = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fl[$urandom_range(0, 16)];
      bus.rt_field = 5'($urandom);
      bus.shamt    = 5'($urandom);
      bus.a        = $urandom;
      bus.b        = $urandom;
      case ($urandom_range(0, 5))
        0: bus.b = bus.a;
        1: bus.a = 32'd0;
        2: bus.a = {bus.a[31], 31'd0};
        default: ;
      endcase
      bus.pc    = $urandom;
      bus.imm16 = 16'($urandom);
      bus.en    = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 49) != 0);
      step();
    end
    reset = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
